// File: rtl/sequencer_playlist.sv
// sequencer_playlist: segment-table driven waveform RAM address sequencer with repeats and chaining.
// Optional feature: define SEQUENCER_PLAYLIST_LOOP_EN to honour loop_playlist.
module sequencer_playlist #(
  parameter int ADDRESS_DEPTH = 14,
  parameter int SEGMENTS_LOG2 = 3,
  parameter int REPEAT_WIDTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     table_write_enable,
  input  logic [SEGMENTS_LOG2-1:0] table_write_index,
  input  logic [ADDRESS_DEPTH-1:0] table_start_address,
  input  logic [ADDRESS_DEPTH-1:0] table_end_address,
  input  logic [REPEAT_WIDTH-1:0]  table_repeat,
  input  logic                     table_last,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_playlist,
  output logic [ADDRESS_DEPTH-1:0] read_address,
  output logic                     read_enable,
  output logic                     segment_sync,
  output logic [SEGMENTS_LOG2-1:0] current_segment,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);
  localparam int N = 1 << SEGMENTS_LOG2;
  typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;
  state_t state;
  logic [ADDRESS_DEPTH-1:0] t_start [N];
  logic [ADDRESS_DEPTH-1:0] t_end [N];
  logic [REPEAT_WIDTH-1:0]  t_rep [N];
  logic                     t_last [N];
  logic [ADDRESS_DEPTH-1:0] w_start, w_end;
  logic [REPEAT_WIDTH-1:0]  w_rep;
  logic                     w_last;
  logic                     loop_en, pass_end, fetch_valid, next_valid;
  logic [SEGMENTS_LOG2-1:0] next_index;
`ifdef SEQUENCER_PLAYLIST_LOOP_EN
  assign loop_en = loop_playlist;
`else
  assign loop_en = loop_playlist && 1'b0;
`endif
  always_comb begin
    next_index  = w_last ? '0 : current_segment + 1'b1;
    next_valid  = t_end[next_index] > t_start[next_index];
    fetch_valid = t_end[current_segment] > t_start[current_segment];
    pass_end    = read_address == w_end - 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        t_start[i] <= '0;
        t_end[i]   <= '0;
        t_rep[i]   <= '0;
        t_last[i]  <= 1'b0;
      end
    end else if (table_write_enable) begin
      t_start[table_write_index] <= table_start_address;
      t_end[table_write_index]   <= table_end_address;
      t_rep[table_write_index]   <= table_repeat;
      t_last[table_write_index]  <= table_last;
    end
  end
  // Outputs are registered alongside the state so each PLAY cycle presents one word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      read_address    <= '0;
      read_enable     <= 1'b0;
      segment_sync    <= 1'b0;
      current_segment <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      w_start         <= '0;
      w_end           <= '0;
      w_rep           <= '0;
      w_last          <= 1'b0;
    end else if (stop && (state == FETCH || state == PLAY)) begin
      state        <= IDLE;
      read_enable  <= 1'b0;
      segment_sync <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start && !stop) begin
          state           <= FETCH;
          current_segment <= '0;
          error           <= 1'b0;
          busy            <= 1'b1;
          done            <= 1'b0;
        end
        FETCH: begin
          w_start <= t_start[current_segment];
          w_end   <= t_end[current_segment];
          w_rep   <= t_rep[current_segment];
          w_last  <= t_last[current_segment];
          if (fetch_valid) begin
            state        <= PLAY;
            read_address <= t_start[current_segment];
            read_enable  <= 1'b1;
            segment_sync <= 1'b1;
          end else begin
            state <= DONE;
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        PLAY: begin
          if (!pass_end) begin
            read_address <= read_address + 1'b1;
            segment_sync <= 1'b0;
          end else if (w_rep != '0) begin
            w_rep        <= w_rep - 1'b1;
            read_address <= w_start;
            segment_sync <= 1'b1;
          end else if ((!w_last || loop_en) && next_valid) begin
            current_segment <= next_index;
            w_start         <= t_start[next_index];
            w_end           <= t_end[next_index];
            w_rep           <= t_rep[next_index];
            w_last          <= t_last[next_index];
            read_address    <= t_start[next_index];
            segment_sync    <= 1'b1;
          end else begin
            state        <= DONE;
            error        <= !w_last || loop_en;
            read_enable  <= 1'b0;
            segment_sync <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequencer_playlist.sv
// tb_sequencer_playlist: directed and random playlists checked against an expected word list.
module tb_sequencer_playlist;
  localparam int AD = 14, SL = 3, RW = 8, N = 8;
  logic clock = 0, reset = 1, table_write_enable = 0;
  logic [SL-1:0] table_write_index = '0;
  logic [AD-1:0] table_start_address = '0, table_end_address = '0;
  logic [RW-1:0] table_repeat = '0;
  logic table_last = 0, start = 0, stop = 0, loop_playlist = 0;
  logic [AD-1:0] read_address;
  logic read_enable, segment_sync, busy, done, error;
  logic [SL-1:0] current_segment;
  sequencer_playlist dut (
    .clock(clock), .reset(reset), .table_write_enable(table_write_enable),
    .table_write_index(table_write_index), .table_start_address(table_start_address),
    .table_end_address(table_end_address), .table_repeat(table_repeat), .table_last(table_last),
    .start(start), .stop(stop), .loop_playlist(loop_playlist), .read_address(read_address),
    .read_enable(read_enable), .segment_sync(segment_sync), .current_segment(current_segment),
    .busy(busy), .done(done), .error(error));
  always #5 clock = ~clock;
  int vectors = 0, miscompares = 0;
  int m_start [N], m_end [N], m_rep [N];
  bit m_last [N];
  typedef struct {int addr; int seg; bit sync;} word_t;
  word_t exp_q[$];
  bit exp_err, exp_trunc;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  function automatic bit loop_on();
`ifdef SEQUENCER_PLAYLIST_LOOP_EN
    return loop_playlist;
`else
    return 1'b0;
`endif
  endfunction
  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_rep[i] = 0; m_last[i] = 0;
    end
  endtask
  // Expected playback: every pass of every chained entry expanded to its word list.
  task automatic build(input int cap);
    int idx;
    idx = 0;
    exp_q.delete();
    exp_err = 0;
    exp_trunc = 0;
    if (m_end[0] <= m_start[0]) begin exp_err = 1; return; end
    forever begin
      for (int p = 0; p <= m_rep[idx]; p++)
        for (int a = m_start[idx]; a < m_end[idx]; a++) begin
          if (exp_q.size() >= cap) begin exp_trunc = 1; return; end
          exp_q.push_back('{a, idx, a == m_start[idx]});
        end
      if (m_last[idx] && !loop_on()) return;
      idx = m_last[idx] ? 0 : (idx + 1) % N;
      if (m_end[idx] <= m_start[idx]) begin exp_err = 1; return; end
    end
  endtask
  task automatic wr(input int i, input int s, input int e, input int r, input bit l);
    table_write_enable = 1;
    table_write_index = SL'(i);
    table_start_address = AD'(s);
    table_end_address = AD'(e);
    table_repeat = RW'(r);
    table_last = l;
    tick();
    table_write_enable = 0;
    m_start[i] = s; m_end[i] = e; m_rep[i] = r; m_last[i] = l;
  endtask
  task automatic run(input int cap, input int wr_at, input int st_at);
    build(cap);
    start = 1;
    tick();
    start = 0;
    check("fetch_busy", busy, 1);
    check("fetch_re", read_enable, 0);
    tick();
    if (exp_q.size() == 0) begin
      check("bad_first_err", error, 1);
      check("bad_first_done", done, 1);
      check("bad_first_re", read_enable, 0);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      check("addr", read_address, exp_q[i].addr);
      check("re", read_enable, 1);
      check("sync", segment_sync, exp_q[i].sync);
      check("seg", current_segment, exp_q[i].seg);
      if (exp_trunc && i == exp_q.size() - 1) begin
        stop = 1;
        tick();
        stop = 0;
        check("stop_re", read_enable, 0);
        check("stop_sync", segment_sync, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        check("stop_hold", read_address, exp_q[i].addr);
        return;
      end
      if (i == wr_at) begin
        table_write_enable = 1;
        table_write_index = '0;
        table_start_address = AD'(m_start[0]);
        table_end_address = AD'(6);
        table_repeat = RW'(m_rep[0]);
        table_last = m_last[0];
      end
      if (i == st_at) start = 1;
      tick();
      table_write_enable = 0;
      start = 0;
      if (i == wr_at) m_end[0] = 6;
    end
    check("end_done", done, 1);
    check("end_err", error, exp_err);
    check("end_re", read_enable, 0);
    check("end_sync", segment_sync, 0);
    check("end_busy", busy, 0);
    check("end_hold", read_address, exp_q[exp_q.size() - 1].addr);
    tick();
    check("done_persist", done, 1);
  endtask
  initial begin
    clear_model();
    table_write_enable = 1;
    table_start_address = AD'(5);
    table_end_address = AD'(9);
    table_last = 1;
    tick();
    tick();
    reset = 0;
    table_write_enable = 0;
    check("rst_addr", read_address, 0);
    check("rst_re", read_enable, 0);
    check("rst_sync", segment_sync, 0);
    check("rst_seg", current_segment, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    run(50, -1, -1);
    wr(0, 16, 20, 1, 1);
    run(100, -1, -1);
    wr(0, 0, 4, 0, 0);
    wr(1, 100, 102, 0, 1);
    run(100, -1, -1);
    wr(0, 8, 8, 0, 1);
    run(100, -1, -1);
    wr(0, 0, 1000, 0, 1);
    run(38, -1, -1);
    run(5, -1, -1);
    wr(0, 0, 4, 0, 1);
    loop_playlist = 1;
    run(20, -1, -1);
    loop_playlist = 0;
    wr(0, 0, 4, 2, 1);
    run(100, 5, 2);
    run(100, -1, -1);
    start = 1;
    stop = 1;
    tick();
    start = 0;
    stop = 0;
    check("startstop_busy", busy, 0);
    check("startstop_done", done, 1);
    start = 1;
    tick();
    start = 0;
    stop = 1;
    tick();
    stop = 0;
    check("fetch_stop_busy", busy, 0);
    check("fetch_stop_re", read_enable, 0);
    check("fetch_stop_done", done, 0);
    wr(0, 0, 100, 0, 1);
    start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    reset = 1;
    tick();
    reset = 0;
    clear_model();
    check("midrst_re", read_enable, 0);
    check("midrst_addr", read_address, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    run(50, -1, -1);
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < N; k++) begin
        int s, e;
        s = $urandom_range(0, 300);
        if ($urandom_range(0, 9) == 0) e = (s >= 2) ? s - $urandom_range(0, 2) : s;
        else e = s + $urandom_range(1, 6);
        wr(k, s, e, $urandom_range(0, 2), $urandom_range(0, 2) == 0);
      end
      loop_playlist = $urandom_range(0, 1);
      run(60, -1, $urandom_range(0, 1) ? $urandom_range(0, 20) : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sequencer_playlist.md
SEQUENCER_PLAYLIST -- requirements
Module: sequencer_playlist

Interface
REQ-001 Parameter ADDRESS_DEPTH, default 14, sets the width of the waveform RAM word address.
REQ-002 Parameter SEGMENTS_LOG2, default 3, sets log2 of the segment-table depth (8 entries).
REQ-003 Parameter REPEAT_WIDTH, default 8, sets the width of the per-segment repeat count.
REQ-004 clock  in  1  single clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 table_write_enable  in  1  writes one segment-table entry in this cycle.
REQ-007 table_write_index  in  SEGMENTS_LOG2  entry to write.
REQ-008 table_start_address  in  ADDRESS_DEPTH  first word of the segment.
REQ-009 table_end_address  in  ADDRESS_DEPTH  end of the segment; exclusive, so the last word is end-1.
REQ-010 table_repeat  in  REPEAT_WIDTH  extra passes; the segment plays repeat+1 times.
REQ-011 table_last  in  1  marks the entry as the end of the playlist.
REQ-012 start  in  1  one-cycle pulse that begins the playlist at entry 0.
REQ-013 stop  in  1  one-cycle pulse that aborts playback.
REQ-014 loop_playlist  in  1  level input; when set, the playlist restarts at entry 0 after the last entry.
REQ-015 read_address  out  ADDRESS_DEPTH  waveform RAM read address.
REQ-016 read_enable  out  1  high while read_address is a valid playback word.
REQ-017 segment_sync  out  1  high on the first word of every segment pass.
REQ-018 current_segment  out  SEGMENTS_LOG2  index of the entry currently playing.
REQ-019 busy  out  1  high in states FETCH and PLAY.
REQ-020 done  out  1  high in state DONE.
REQ-021 error  out  1  sticky flag indicating an invalid entry was fetched.

Function
REQ-022 The state machine SHALL have four states: IDLE, FETCH, PLAY and DONE.
REQ-023 The segment table SHALL be a register array with combinational read; a write lands on the edge where table_write_enable is high and is accepted in any state.
REQ-024 Working registers SHALL latch start, end, repeat and last when an entry is fetched, so table writes during a pass do not affect that pass.
REQ-025 start in IDLE or DONE: go to FETCH the next cycle with index 0 and clear error; start in FETCH or PLAY is ignored.
REQ-026 FETCH: latch entry[index]; if end <= start (unsigned), set error and go to DONE; otherwise go to PLAY.
REQ-027 The first PLAY cycle SHALL drive read_address = start, read_enable = 1 and segment_sync = 1, giving 2 cycles of latency from start to the first word.
REQ-028 In PLAY, read_address SHALL increment by 1 each cycle until it equals end-1.
REQ-029 Pass wrap at end-1 with repeats_left > 0: decrement repeats_left, and on the next cycle drive read_address = start with segment_sync = 1, leaving no gap.
REQ-030 End of the final pass on an entry not marked last: the next entry SHALL be read combinationally and validated in the same cycle; if valid, play its start next cycle with segment_sync = 1 and current_segment incremented, leaving no gap; if invalid, set error and go to DONE.
REQ-031 End of the final pass on an entry marked last: if looping is enabled, continue seamlessly at entry 0 per REQ-030; otherwise go to DONE.
REQ-032 The index SHALL wrap from 2^SEGMENTS_LOG2-1 to 0 when no entry is marked last.
REQ-033 A single-word segment (end = start+1) SHALL be legal and produce segment_sync on every pass.
REQ-034 stop in FETCH or PLAY: go to IDLE the next cycle with read_enable = 0 and segment_sync = 0; stop has priority over every other transition.
REQ-035 If start and stop occur in the same cycle, stop SHALL take priority.
REQ-036 In IDLE and DONE, read_enable and segment_sync SHALL be 0 and read_address SHALL hold its last value.
REQ-037 DONE SHALL persist until start or reset.

Reset
REQ-038 On reset: state = IDLE; read_address, read_enable, segment_sync, current_segment, busy, done and error = 0; all table entries are cleared to zero.
REQ-039 Reset SHALL win over start, stop and table writes in the same cycle, and aborts playback mid-segment.

Configuration
REQ-040 With macro SEQUENCER_PLAYLIST_LOOP_EN defined, loop_playlist SHALL be honoured as in REQ-031.
REQ-041 Without SEQUENCER_PLAYLIST_LOOP_EN, the port SHALL still exist but be ignored, and the last entry always goes to DONE.

Verification
REQ-042 Entry0 = {start 16, end 20, repeat 1, last 1}, then start: read_address sequence 16,17,18,19,16,17,18,19; segment_sync high at both 16s; then done = 1.
REQ-043 Entry0 = {0,4,0,0} and entry1 = {100,102,0,1}: addresses 0,1,2,3,100,101 with no gap; segment_sync at 0 and at 100; current_segment changes 0 -> 1 on the cycle address 100 is driven.
REQ-044 Entry0 = {8,8,0,1} and start: error = 1 and done = 1 two cycles after start, with read_enable never asserted.
REQ-045 Playing {0,1000,0,1}, stop at address 37: read_enable = 0 the next cycle, state IDLE, read_address holds 37; a following start replays from 0.
REQ-046 Playing {0,4,0,1} with loop_playlist = 1: addresses 0..3 repeat continuously with segment_sync every 4 cycles (macro defined); without the macro, done = 1 after one pass.
REQ-047 Write entry0 end = 6 mid-pass of {0,4,2,1}: all 3 passes still end at 3, and the next start plays 0..5.
